// File: rtl/raycast_pkg.sv
// Shared raycaster types: fixed-point word, ray-descriptor beat, screen geometry.
// Used by both the ray stream sender and the DDA FSM on the other side of the FIFO.
package raycast_pkg;

    localparam int N             = 24;
    localparam int FRAC          = 16;
    localparam int SCREEN_WIDTH  = 320;
    localparam int SCREEN_HEIGHT = 240;

    typedef logic signed [N-1:0] fixed_t;

    typedef struct packed {
        logic [8:0] col;
        fixed_t     ray_dir_x;
        fixed_t     ray_dir_y;
    } ray_beat_t;

endpackage

// File: rtl/fx_mul.sv
// fx_mul: signed N x N multiplier producing the full 2N-bit product.
// Latency: 1 cycle (single output register, loaded when en_i is high).
// Backpressure: none; the caller holds operands and decides when to load.
module fx_mul #(
    parameter int N = raycast_pkg::N
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  en_i,
    input  logic signed [N-1:0]   a_i,
    input  logic signed [N-1:0]   b_i,
    output logic signed [2*N-1:0] p_o
);

    logic signed [2*N-1:0] p_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            p_q <= '0;
        end else if (en_i) begin
            p_q <= (2*N)'(a_i) * (2*N)'(b_i);
        end
    end

    assign p_o = p_q;

endmodule

// File: rtl/ray_stream_sender.sv
// ray_stream_sender: per-frame ray-direction generator, one AXI-Stream beat per screen column.
// Latency: tvalid 2 cycles after start_in is sampled; 2 idle cycles after every handshake (1 beat / 3 cycles).
// Backpressure: beat held stable until tready; optional stall counter under RAY_STREAM_STALL_CNT_EN.
module ray_stream_sender #(
    parameter int SCREEN_WIDTH = raycast_pkg::SCREEN_WIDTH,
    parameter int N            = raycast_pkg::N,
    parameter int FRAC         = raycast_pkg::FRAC
) (
    input  logic              pixel_clk_in,
    input  logic              rst_in,
    input  logic              start_in,
    input  logic [N-1:0]      dir_x_in,
    input  logic [N-1:0]      dir_y_in,
    input  logic [N-1:0]      plane_x_in,
    input  logic [N-1:0]      plane_y_in,
    output logic              ray_axis_tvalid,
    input  logic              ray_axis_tready,
    output logic [9+2*N-1:0]  ray_axis_tdata,
    output logic              ray_axis_tlast,
    output logic              busy_out,
    output logic              frame_done_out,
    output logic [15:0]       stall_count_out
);

    localparam int CW = 9;
    localparam logic [CW-1:0]       LAST_COL  = CW'(SCREEN_WIDTH - 1);
    localparam logic signed [N-1:0] STEP      = N'((2 << FRAC) / SCREEN_WIDTH);
    localparam logic signed [N-1:0] CAM_START = N'(-(1 << FRAC));

    typedef enum logic [1:0] {IDLE, MUL, SUM, SEND} state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         col_q, col_d;
    logic signed [N-1:0]   cam_x_q, cam_x_d;
    logic signed [N-1:0]   dir_x_q, dir_x_d, dir_y_q, dir_y_d;
    logic signed [N-1:0]   plane_x_q, plane_x_d, plane_y_q, plane_y_d;
    logic                  tvalid_q, tvalid_d;
    logic                  tlast_q, tlast_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [CW+2*N-1:0]     tdata_q, tdata_d;

    logic signed [2*N-1:0] prod_x, prod_y;
    logic [N-1:0]          ray_x, ray_y;
    logic                  accept_start;
    logic                  handshake;
    logic                  mul_en;
    logic                  unused_prod_bits;

    assign accept_start = (state_q == IDLE) && start_in;
    assign handshake    = (state_q == SEND) && ray_axis_tready;
    assign mul_en       = (state_q == MUL);

    fx_mul #(.N(N)) u_mul_x (
        .clk_i (pixel_clk_in),
        .rst_i (rst_in),
        .en_i  (mul_en),
        .a_i   (plane_x_q),
        .b_i   (cam_x_q),
        .p_o   (prod_x)
    );

    fx_mul #(.N(N)) u_mul_y (
        .clk_i (pixel_clk_in),
        .rst_i (rst_in),
        .en_i  (mul_en),
        .a_i   (plane_y_q),
        .b_i   (cam_x_q),
        .p_o   (prod_y)
    );

    // Taking bits [FRAC+N-1:FRAC] is a flooring arithmetic shift back to Q.FRAC.
    assign ray_x = dir_x_q + prod_x[FRAC+N-1:FRAC];
    assign ray_y = dir_y_q + prod_y[FRAC+N-1:FRAC];
    assign unused_prod_bits = ^{prod_x[2*N-1:FRAC+N], prod_x[FRAC-1:0],
                                prod_y[2*N-1:FRAC+N], prod_y[FRAC-1:0]};

    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        cam_x_d   = cam_x_q;
        dir_x_d   = dir_x_q;
        dir_y_d   = dir_y_q;
        plane_x_d = plane_x_q;
        plane_y_d = plane_y_q;
        tvalid_d  = tvalid_q;
        tlast_d   = tlast_q;
        tdata_d   = tdata_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_in) begin
                    dir_x_d   = dir_x_in;
                    dir_y_d   = dir_y_in;
                    plane_x_d = plane_x_in;
                    plane_y_d = plane_y_in;
                    col_d     = '0;
                    cam_x_d   = CAM_START;
                    busy_d    = 1'b1;
                    state_d   = MUL;
                end
            end
            MUL: begin
                state_d = SUM;
            end
            SUM: begin
                tdata_d  = {col_q, ray_x, ray_y};
                tvalid_d = 1'b1;
                tlast_d  = (col_q == LAST_COL);
                state_d  = SEND;
            end
            SEND: begin
                if (ray_axis_tready) begin
                    tvalid_d = 1'b0;
                    tlast_d  = 1'b0;
                    if (tlast_q) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        col_d   = col_q + 1'b1;
                        cam_x_d = cam_x_q + STEP;
                        state_d = MUL;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
            state_q   <= IDLE;
            col_q     <= '0;
            cam_x_q   <= '0;
            dir_x_q   <= '0;
            dir_y_q   <= '0;
            plane_x_q <= '0;
            plane_y_q <= '0;
            tvalid_q  <= 1'b0;
            tlast_q   <= 1'b0;
            tdata_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            col_q     <= col_d;
            cam_x_q   <= cam_x_d;
            dir_x_q   <= dir_x_d;
            dir_y_q   <= dir_y_d;
            plane_x_q <= plane_x_d;
            plane_y_q <= plane_y_d;
            tvalid_q  <= tvalid_d;
            tlast_q   <= tlast_d;
            tdata_q   <= tdata_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

`ifdef RAY_STREAM_STALL_CNT_EN
    logic [15:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (accept_start) begin
            stall_d = '0;
        end else if (tvalid_q && !ray_axis_tready && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_count_out = stall_q;
`else
    assign stall_count_out = 16'd0;
`endif

    assign ray_axis_tvalid = tvalid_q;
    assign ray_axis_tdata  = tdata_q;
    assign ray_axis_tlast  = tlast_q;
    assign busy_out        = busy_q;
    assign frame_done_out  = done_q;

endmodule

// File: tb/tb_ray_stream_sender.sv
// Bench for ray_stream_sender: known-value table, latency/corner sequences, randomized
// frames under backpressure checked against an arithmetic ray model.
`timescale 1ns/1ps
module tb_ray_stream_sender;

    localparam int W    = 320;
    localparam int N    = 24;
    localparam int FRAC = 16;
    localparam int STEP = (2 << FRAC) / W;
    localparam int DW   = 9 + 2*N;

    logic                clk    = 1'b0;
    logic                rst    = 1'b1;
    logic                start  = 1'b0;
    logic signed [N-1:0] dx     = '0;
    logic signed [N-1:0] dy     = '0;
    logic signed [N-1:0] px     = '0;
    logic signed [N-1:0] py     = '0;
    logic                tready = 1'b0;
    logic                tvalid;
    logic [DW-1:0]       tdata;
    logic                tlast;
    logic                busy;
    logic                done;
    logic [15:0]         stall_cnt;

    always #5 clk = ~clk;

    ray_stream_sender dut (
        .pixel_clk_in    (clk),
        .rst_in          (rst),
        .start_in        (start),
        .dir_x_in        (dx),
        .dir_y_in        (dy),
        .plane_x_in      (px),
        .plane_y_in      (py),
        .ray_axis_tvalid (tvalid),
        .ray_axis_tready (tready),
        .ray_axis_tdata  (tdata),
        .ray_axis_tlast  (tlast),
        .busy_out        (busy),
        .frame_done_out  (done),
        .stall_count_out (stall_cnt)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference: camera_x steps linearly from -1.0; ray = dir + floor(plane*camera_x), wrapped to N bits.
    function automatic longint model_dir(input longint d, input longint p, input int col);
        longint one, cam, r;
        one = 1;
        cam = -(one <<< FRAC) + longint'(col) * STEP;
        r   = d + ((p * cam) >>> FRAC);
        r   = r & ((one <<< N) - 1);
        if (r >= (one <<< (N-1))) r = r - (one <<< N);
        return r;
    endfunction

    typedef struct {
        int     col;
        longint x;
        longint y;
        bit     last;
    } beat_t;

    beat_t               got[$];
    beat_t               mb;
    int                  done_pulses  = 0;
    int                  stall_cycles = 0;
    int                  unstable     = 0;
    bit                  prev_stall   = 1'b0;
    logic [DW-1:0]       prev_data;
    logic                prev_last;
    logic signed [N-1:0] mon_x, mon_y;

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (done) done_pulses++;
            if (tvalid) begin
                if (prev_stall && (tdata !== prev_data || tlast !== prev_last)) unstable++;
                if (tready) begin
                    mon_x   = tdata[2*N-1:N];
                    mon_y   = tdata[N-1:0];
                    mb.col  = int'(tdata[DW-1:2*N]);
                    mb.x    = longint'(mon_x);
                    mb.y    = longint'(mon_y);
                    mb.last = tlast;
                    got.push_back(mb);
                end else begin
                    stall_cycles++;
                end
                prev_stall = !tready;
                prev_data  = tdata;
                prev_last  = tlast;
            end else begin
                prev_stall = 1'b0;
            end
        end
    end

    task automatic start_frame(input longint ax, input longint ay, input longint bx, input longint by);
        @(posedge clk); #1;
        got.delete();
        stall_cycles = 0;
        unstable     = 0;
        done_pulses  = 0;
        dx    = N'(ax);
        dy    = N'(ay);
        px    = N'(bx);
        py    = N'(by);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic run_frame(input int budget, input bit rnd);
        int cyc;
        int burst;
        cyc   = 0;
        burst = 0;
        while (done_pulses == 0 && cyc < budget) begin
            if (!rnd) tready = 1'b1;
            else if (burst > 0) begin tready = 1'b0; burst--; end
            else if ($urandom_range(0, 99) < 2) begin tready = 1'b0; burst = 50; end
            else tready = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
            cyc++;
        end
        tready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("frame_done_pulses", done_pulses, 1);
    endtask

    task automatic wait_beats(input int n);
        int cyc;
        cyc = 0;
        while (got.size() < n && cyc < 5000) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("reached_beat", (got.size() >= n), 1);
    endtask

    task automatic check_frame(input longint ax, input longint ay, input longint bx, input longint by);
        chk("beat_count", got.size(), W);
        for (int i = 0; i < got.size(); i++) begin
            chk($sformatf("col%0d_index", i), got[i].col, i);
            chk($sformatf("col%0d_dir_x", i), got[i].x, model_dir(ax, bx, i));
            chk($sformatf("col%0d_dir_y", i), got[i].y, model_dir(ay, by, i));
            chk($sformatf("col%0d_tlast", i), got[i].last, (i == W-1));
        end
    endtask

    typedef struct {
        longint dx, dy, px, py;
        int     col;
        longint ex, ey;
        bit     elast;
    } vec_t;

    vec_t tbl[6];

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        longint lx, ly, lpx, lpy;
        longint rx, ry, rpx, rpy;
        bit     have;
        int     nlast;

        tbl[0] = '{65536, 0, 0, 43254,   0, 65536, -43254, 1'b0};
        tbl[1] = '{65536, 0, 0, 43254, 160, 65536,    -64, 1'b0};
        tbl[2] = '{65536, 0, 0, 43254, 319, 65536,  42857, 1'b1};
        tbl[3] = '{0, 65536, -43254, 0,   0,  43254, 65536, 1'b0};
        tbl[4] = '{0, 65536, -43254, 0, 160,     63, 65536, 1'b0};
        tbl[5] = '{0, 65536, -43254, 0, 319, -42858, 65536, 1'b1};

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_tvalid", tvalid, 0);
        chk("rst_tlast", tlast, 0);
        chk("rst_tdata", longint'(tdata), 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_stall", stall_cnt, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // known-value table
        have = 1'b0;
        lx = 0; ly = 0; lpx = 0; lpy = 0;
        for (int i = 0; i < 6; i++) begin
            if (!have || tbl[i].dx != lx || tbl[i].dy != ly || tbl[i].px != lpx || tbl[i].py != lpy) begin
                start_frame(tbl[i].dx, tbl[i].dy, tbl[i].px, tbl[i].py);
                run_frame(20000, 1'b0);
                chk("tbl_beat_count", got.size(), W);
                have = 1'b1;
                lx = tbl[i].dx; ly = tbl[i].dy; lpx = tbl[i].px; lpy = tbl[i].py;
            end
            if (tbl[i].col < got.size()) begin
                chk($sformatf("tbl%0d_col", i), got[tbl[i].col].col, tbl[i].col);
                chk($sformatf("tbl%0d_x", i), got[tbl[i].col].x, tbl[i].ex);
                chk($sformatf("tbl%0d_y", i), got[tbl[i].col].y, tbl[i].ey);
                chk($sformatf("tbl%0d_last", i), got[tbl[i].col].last, tbl[i].elast);
            end else begin
                chk($sformatf("tbl%0d_missing", i), got.size(), tbl[i].col + 1);
            end
        end

        // latency: start at edge k, tready low; then a handshake at edge h
        tready = 1'b0;
        start_frame(65536, 0, 0, 43254);
        @(negedge clk);
        chk("lat_busy_k", busy, 1);
        chk("lat_valid_k", tvalid, 0);
        @(negedge clk);
        chk("lat_valid_k1", tvalid, 0);
        @(negedge clk);
        chk("lat_valid_k2", tvalid, 1);
        repeat (3) @(negedge clk);
        chk("lat_hold_valid", tvalid, 1);
        @(posedge clk); #1;
        tready = 1'b1;
        @(posedge clk); #1;
        tready = 1'b0;
        @(negedge clk);
        chk("lat_valid_h", tvalid, 0);
        @(negedge clk);
        chk("lat_valid_h1", tvalid, 0);
        @(negedge clk);
        chk("lat_valid_h2", tvalid, 1);
        run_frame(20000, 1'b0);
        check_frame(65536, 0, 0, 43254);
        chk("lat_unstable", unstable, 0);

        // mid-frame input change and second start are ignored
        start_frame(65536, 0, 0, 43254);
        tready = 1'b1;
        wait_beats(100);
        dx = N'(-20000); dy = N'(30000); px = N'(12345); py = N'(-6789);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        run_frame(20000, 1'b0);
        check_frame(65536, 0, 0, 43254);
        repeat (10) @(negedge clk);
        chk("mid_no_restart_busy", busy, 0);
        chk("mid_no_restart_valid", tvalid, 0);

        // start coinciding with the final handshake is ignored
        start_frame(0, 65536, -43254, 0);
        tready = 1'b1;
        begin
            int cyc;
            cyc = 0;
            @(negedge clk);
            while (!(tvalid && tlast) && cyc < 5000) begin
                @(negedge clk);
                cyc++;
            end
        end
        chk("final_hs_found", (tvalid && tlast), 1);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(negedge clk);
        chk("final_start_busy", busy, 0);
        chk("final_start_done_pulses", done_pulses, 1);
        chk("final_start_beats", got.size(), W);

        // reset mid-frame, then a fresh frame restarts at col 0
        start_frame(65536, 0, 0, 43254);
        tready = 1'b1;
        wait_beats(50);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mrst_tvalid", tvalid, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_tlast", tlast, 0);
        chk("mrst_done", done, 0);
        chk("mrst_stall", stall_cnt, 0);
        nlast = 0;
        foreach (got[i]) if (got[i].last) nlast++;
        chk("mrst_no_tlast", nlast, 0);
        repeat (5) @(negedge clk);
        chk("mrst_stays_idle", busy, 0);
        start_frame(-65536, 0, 0, -43254);
        run_frame(20000, 1'b0);
        check_frame(-65536, 0, 0, -43254);

        // randomized vectors under random backpressure with long stalls
        for (int r = 0; r < 3; r++) begin
            rx  = longint'($urandom_range(0, 131072)) - 65536;
            ry  = longint'($urandom_range(0, 131072)) - 65536;
            rpx = longint'($urandom_range(0, 131072)) - 65536;
            rpy = longint'($urandom_range(0, 131072)) - 65536;
            tready = 1'b0;
            start_frame(rx, ry, rpx, rpy);
            run_frame(40000, 1'b1);
            check_frame(rx, ry, rpx, rpy);
            chk($sformatf("rnd%0d_unstable", r), unstable, 0);
            repeat (10) @(negedge clk);
`ifdef RAY_STREAM_STALL_CNT_EN
            chk($sformatf("rnd%0d_stall_count", r), stall_cnt, (stall_cycles > 65535) ? 65535 : stall_cycles);
`else
            chk($sformatf("rnd%0d_stall_tied", r), stall_cnt, 0);
`endif
            chk($sformatf("rnd%0d_idle_busy", r), busy, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
